// File: rtl/wb_cfg_master.sv
// Wishbone classic single-transfer initiator: one bus read or write per accepted command, result on a response stream.
// Optional bus timeout is compiled in with `define WB_MASTER_TIMEOUT_EN (otherwise the bus waits for ack indefinitely).
module wb_cfg_master #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned TO_W           = 16
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,

   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_we,
   input  logic [31:0] cmd_adr,
   input  logic [31:0] cmd_dat,
   input  logic [3:0]  cmd_sel,

   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_dat,
   output logic        rsp_err,

   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   output logic [3:0]  wbm_sel_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i
);

   if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535) || ((TIMEOUT_CYCLES >> TO_W) != 0)) begin : g_param_err
      $error("wb_cfg_master: TIMEOUT_CYCLES out of range or does not fit in TO_W bits");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state_q;

   assign cmd_ready = (state_q == IDLE);
   // A single register drives both so cyc and stb can never diverge.
   assign wbm_stb_o = wbm_cyc_o;

`ifdef WB_MASTER_TIMEOUT_EN
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   logic [TO_W-1:0] to_cnt_q;
`else
   assign rsp_err = 1'b0;
`endif

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q   <= IDLE;
         wbm_cyc_o <= 1'b0;
         wbm_we_o  <= 1'b0;
         wbm_adr_o <= '0;
         wbm_dat_o <= '0;
         wbm_sel_o <= '0;
         rsp_valid <= 1'b0;
         rsp_dat   <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
         rsp_err   <= 1'b0;
         to_cnt_q  <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  wbm_we_o  <= cmd_we;
                  wbm_adr_o <= cmd_adr;
                  wbm_dat_o <= cmd_dat;
                  wbm_sel_o <= cmd_sel;
                  wbm_cyc_o <= 1'b1;
                  state_q   <= BUS;
`ifdef WB_MASTER_TIMEOUT_EN
                  to_cnt_q  <= '0;
`endif
               end
            end

            BUS: begin
               // Ack wins over a timeout expiring at the same edge.
               if (wbm_ack_i) begin
                  wbm_cyc_o <= 1'b0;
                  rsp_dat   <= wbm_we_o ? 32'h0 : wbm_dat_i;
                  rsp_valid <= 1'b1;
                  state_q   <= RESP;
`ifdef WB_MASTER_TIMEOUT_EN
                  rsp_err   <= 1'b0;
               end else if (to_cnt_q == TO_LAST) begin
                  wbm_cyc_o <= 1'b0;
                  rsp_dat   <= 32'h0;
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  state_q   <= RESP;
               end else begin
                  to_cnt_q  <= to_cnt_q + TO_W'(1);
`endif
               end
            end

            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state_q   <= IDLE;
               end
            end

            default: begin
               wbm_cyc_o <= 1'b0;
               rsp_valid <= 1'b0;
               state_q   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_cfg_master.sv
// Directed bench for wb_cfg_master: reset, write, zero-wait read, backpressure, back-to-back, mid-transfer reset, timeout.
module tb_wb_cfg_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_we = 1'b0;
   logic [31:0] cmd_adr = '0;
   logic [31:0] cmd_dat = '0;
   logic [3:0]  cmd_sel = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_dat;
   logic        rsp_err;
   logic        cyc, stb, we;
   logic [31:0] adr, dat_o;
   logic [3:0]  sel;
   logic [31:0] dat_i = '0;
   logic        ack = 1'b0;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   wb_cfg_master #(.TIMEOUT_CYCLES(8), .TO_W(16)) dut (
      .wb_clk_i(clk),        .wb_rst_i(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_adr(cmd_adr),     .cmd_dat(cmd_dat),     .cmd_sel(cmd_sel),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
      .wbm_cyc_o(cyc),       .wbm_stb_o(stb),       .wbm_we_o(we),
      .wbm_adr_o(adr),       .wbm_dat_o(dat_o),     .wbm_sel_o(sel),
      .wbm_dat_i(dat_i),     .wbm_ack_i(ack)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents a command while IDLE; it is accepted at the next edge.
   task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s; cmd_valid = 1'b1;
      n_cmp++;
      if (cmd_ready !== 1'b1) begin
         n_fail++; $display("FAIL send_cmd_ready: got %b want 1", cmd_ready);
      end
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      n_cmp++;
      if ({cyc, stb, we, rsp_valid, rsp_err, cmd_ready} !== 6'b000001) begin
         n_fail++; $display("FAIL reset_ctrl: got %b want 000001", {cyc, stb, we, rsp_valid, rsp_err, cmd_ready});
      end
      n_cmp++;
      if ({adr, dat_o, sel, rsp_dat} !== 100'h0) begin
         n_fail++; $display("FAIL reset_data: got %h want 0", {adr, dat_o, sel, rsp_dat});
      end
      // Ack while idle must not start anything.
      ack = 1'b1; step(); ack = 1'b0;
      n_cmp++;
      if ({cyc, rsp_valid, cmd_ready} !== 3'b001) begin
         n_fail++; $display("FAIL idle_ack_ignored: got %b want 001", {cyc, rsp_valid, cmd_ready});
      end
   endtask

   task automatic test_write();
      send_cmd(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF);
      for (int k = 1; k <= 3; k++) begin
         n_cmp++;
         if ({cyc, stb, we, adr, dat_o, sel, cmd_ready} !== {3'b111, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 1'b0}) begin
            n_fail++; $display("FAIL write_bus_cycle%0d: got cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h want 1 1 1 30000004 a5a51234 f",
                               k, cyc, stb, we, adr, dat_o, sel);
         end
         if (k == 3) ack = 1'b1;
         step();
      end
      ack = 1'b0;
      n_cmp++;
      if ({cyc, stb, rsp_valid, rsp_err, rsp_dat} !== {4'b0010, 32'h0}) begin
         n_fail++; $display("FAIL write_rsp: got cyc=%b stb=%b vld=%b err=%b dat=%h want 0 0 1 0 0", cyc, stb, rsp_valid, rsp_err, rsp_dat);
      end
      rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
      n_cmp++;
      if ({rsp_valid, cmd_ready} !== 2'b01) begin
         n_fail++; $display("FAIL write_done: got vld=%b cmd_ready=%b want 0 1", rsp_valid, cmd_ready);
      end
   endtask

   task automatic test_read_backpressure();
      send_cmd(1'b0, 32'h3000_0010, 32'h0, 4'hF);
      n_cmp++;
      if ({cyc, we, adr} !== {2'b10, 32'h3000_0010}) begin
         n_fail++; $display("FAIL read_bus: got cyc=%b we=%b adr=%h want 1 0 30000010", cyc, we, adr);
      end
      ack = 1'b1; dat_i = 32'hCAFE_F00D;
      step();
      ack = 1'b0; dat_i = 32'h1357_9BDF;
      n_cmp++;
      if ({cyc, rsp_valid, rsp_err, rsp_dat} !== {3'b010, 32'hCAFE_F00D}) begin
         n_fail++; $display("FAIL read_rsp: got cyc=%b vld=%b err=%b dat=%h want 0 1 0 cafef00d", cyc, rsp_valid, rsp_err, rsp_dat);
      end
      for (int k = 0; k < 5; k++) begin
         step();
         n_cmp++;
         if ({cyc, rsp_valid, cmd_ready, rsp_dat} !== {3'b010, 32'hCAFE_F00D}) begin
            n_fail++; $display("FAIL backpressure_hold%0d: got cyc=%b vld=%b cmd_ready=%b dat=%h want 0 1 0 cafef00d",
                               k, cyc, rsp_valid, cmd_ready, rsp_dat);
         end
      end
      rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
      n_cmp++;
      if ({rsp_valid, cmd_ready} !== 2'b01) begin
         n_fail++; $display("FAIL backpressure_release: got vld=%b cmd_ready=%b want 0 1", rsp_valid, cmd_ready);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] c_adr [4] = '{32'h10, 32'h14, 32'h18, 32'h1C};
      logic [31:0] c_dat [4] = '{32'h1111_1111, 32'h0, 32'h3333_3333, 32'h0};
      logic        c_we  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic [31:0] s_dat [4] = '{32'h0BAD_0000, 32'h2222_0014, 32'h0BAD_0002, 32'hDEAD_BEEF};
      logic [31:0] r_exp [4] = '{32'h0, 32'h2222_0014, 32'h0, 32'hDEAD_BEEF};
      int ci = 0, bi = 0, ri = 0;
      logic prev_cyc = 1'b0;
      logic acc;
      rsp_ready = 1'b1;
      cmd_we = c_we[0]; cmd_adr = c_adr[0]; cmd_dat = c_dat[0]; cmd_sel = 4'hF; cmd_valid = 1'b1;
      for (int cy = 0; cy < 60 && ri < 4; cy++) begin
         acc = cmd_valid & cmd_ready;
         if (cyc) begin
            n_cmp++;
            if (prev_cyc || bi > 3 || adr !== c_adr[bi & 3] || we !== c_we[bi & 3] || (c_we[bi & 3] && dat_o !== c_dat[bi & 3])) begin
               n_fail++; $display("FAIL b2b_bus%0d: got adr=%h we=%b dat=%h prev_cyc=%b want adr=%h we=%b dat=%h prev_cyc=0",
                                  bi, adr, we, dat_o, prev_cyc, c_adr[bi & 3], c_we[bi & 3], c_dat[bi & 3]);
            end
            ack = 1'b1; dat_i = s_dat[bi & 3];
            bi++;
         end
         if (rsp_valid) begin
            n_cmp++;
            if (rsp_dat !== r_exp[ri] || rsp_err !== 1'b0) begin
               n_fail++; $display("FAIL b2b_rsp%0d: got dat=%h err=%b want %h 0", ri, rsp_dat, rsp_err, r_exp[ri]);
            end
            ri++;
         end
         prev_cyc = cyc;
         step();
         ack = 1'b0;
         if (acc) begin
            ci++;
            if (ci < 4) begin
               cmd_we = c_we[ci]; cmd_adr = c_adr[ci]; cmd_dat = c_dat[ci];
            end else begin
               cmd_valid = 1'b0;
            end
         end
      end
      cmd_valid = 1'b0; rsp_ready = 1'b0;
      n_cmp++;
      if (ci != 4 || bi != 4 || ri != 4) begin
         n_fail++; $display("FAIL b2b_counts: got cmds=%0d bus=%0d rsps=%0d want 4 4 4", ci, bi, ri);
      end
      step();
   endtask

   task automatic test_reset_mid();
      send_cmd(1'b1, 32'h0000_0040, 32'h7777_8888, 4'h3);
      step();
      rst = 1'b1; step(); rst = 1'b0;
      n_cmp++;
      if ({cyc, stb, we, rsp_valid, rsp_err, cmd_ready} !== 6'b000001 || {adr, dat_o, sel, rsp_dat} !== 100'h0) begin
         n_fail++; $display("FAIL reset_mid: got ctrl=%b data=%h want 000001 and 0",
                            {cyc, stb, we, rsp_valid, rsp_err, cmd_ready}, {adr, dat_o, sel, rsp_dat});
      end
      ack = 1'b1; step(); ack = 1'b0; step();
      n_cmp++;
      if ({cyc, rsp_valid} !== 2'b00) begin
         n_fail++; $display("FAIL reset_mid_no_rsp: got cyc=%b vld=%b want 0 0", cyc, rsp_valid);
      end
      send_cmd(1'b0, 32'h0000_0044, 32'h0, 4'hC);
      step();
      ack = 1'b1; dat_i = 32'h4455_6677;
      step();
      ack = 1'b0;
      n_cmp++;
      if ({cyc, rsp_valid, rsp_err, rsp_dat} !== {3'b010, 32'h4455_6677}) begin
         n_fail++; $display("FAIL reset_mid_next: got cyc=%b vld=%b err=%b dat=%h want 0 1 0 44556677", cyc, rsp_valid, rsp_err, rsp_dat);
      end
      rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
   endtask

   task automatic test_timeout();
      int cnt;
`ifdef WB_MASTER_TIMEOUT_EN
      send_cmd(1'b0, 32'h0000_0080, 32'h0, 4'hF);
      cnt = 0;
      while (cyc && cnt < 40) begin cnt++; step(); end
      n_cmp++;
      if (cnt != 8) begin
         n_fail++; $display("FAIL timeout_len: got %0d cycles want 8", cnt);
      end
      n_cmp++;
      if ({rsp_valid, rsp_err, rsp_dat} !== {2'b11, 32'h0}) begin
         n_fail++; $display("FAIL timeout_rsp: got vld=%b err=%b dat=%h want 1 1 0", rsp_valid, rsp_err, rsp_dat);
      end
      rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
      send_cmd(1'b0, 32'h0000_0084, 32'h0, 4'hF);
      for (int k = 1; k <= 8; k++) begin
         if (k == 8) begin ack = 1'b1; dat_i = 32'h1234_5678; end
         step();
      end
      ack = 1'b0;
      n_cmp++;
      if ({cyc, rsp_valid, rsp_err, rsp_dat} !== {3'b010, 32'h1234_5678}) begin
         n_fail++; $display("FAIL timeout_ack_wins: got cyc=%b vld=%b err=%b dat=%h want 0 1 0 12345678", cyc, rsp_valid, rsp_err, rsp_dat);
      end
`else
      send_cmd(1'b0, 32'h0000_0080, 32'h0, 4'hF);
      cnt = 0;
      while (cyc && cnt < 20) begin cnt++; step(); end
      n_cmp++;
      if (cnt != 20 || {cyc, rsp_valid, rsp_err} !== 3'b100) begin
         n_fail++; $display("FAIL no_timeout_wait: got %0d cycles cyc=%b vld=%b err=%b want 20 1 0 0", cnt, cyc, rsp_valid, rsp_err);
      end
      ack = 1'b1; dat_i = 32'h1234_5678;
      step();
      ack = 1'b0;
      n_cmp++;
      if ({cyc, rsp_valid, rsp_err, rsp_dat} !== {3'b010, 32'h1234_5678}) begin
         n_fail++; $display("FAIL no_timeout_late_ack: got cyc=%b vld=%b err=%b dat=%h want 0 1 0 12345678", cyc, rsp_valid, rsp_err, rsp_dat);
      end
`endif
      rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_write();
      test_read_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_timeout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
